slda_stage_sequencer: RTL and testbench

Control sequencer for the SLDA accelerator top level. It accepts one top-level ap_ctrl_hs transaction and runs the three compute kernels strictly in order over their ap_ctrl_hs handshakes: stage 0 = compute_weights_with_matrix_mult, stage 1 = compute_biases_with_multiple_dot_products, stage 2 = compute_scores. It adds a per-run stage skip mask, a per-stage watchdog and a run-length cycle counter. It replaces ad-hoc start chaining, and its handshakes are the ones the dataflow status monitors sample.

---
 rtl/slda_stage_sequencer_if.sv | 31 +++
 rtl/slda_stage_sequencer.sv | 133 +++++++++++++
 tb/tb_slda_stage_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/slda_stage_sequencer_if.sv
// Handshake bundle between the SLDA top-level controller, the stage sequencer and its kernels.
// slave is the sequencer side; master is the host/kernel side.
interface slda_stage_sequencer_if #(
  parameter int NUM_STAGES = 3,
  parameter int CNT_W      = 32
);
  localparam int SEL_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic                  ap_start;
  logic                  ap_ready;
  logic                  ap_done;
  logic                  ap_idle;
  logic                  ap_continue;
  logic [NUM_STAGES-1:0] skip_mask;
  logic [NUM_STAGES-1:0] stage_start;
  logic [NUM_STAGES-1:0] stage_ready;
  logic [NUM_STAGES-1:0] stage_done;
  logic [SEL_W-1:0]      stage_sel;
  logic [CNT_W-1:0]      run_cycles;
  logic                  err_timeout;

  modport slave (
    input  ap_start, ap_continue, skip_mask, stage_ready, stage_done,
    output ap_ready, ap_done, ap_idle, stage_start, stage_sel, run_cycles, err_timeout
  );

  modport master (
    output ap_start, ap_continue, skip_mask, stage_ready, stage_done,
    input  ap_ready, ap_done, ap_idle, stage_start, stage_sel, run_cycles, err_timeout
  );
endinterface

// File: rtl/slda_stage_sequencer.sv
// Runs the SLDA kernels in index order over ap_ctrl_hs, with per-run skip mask, per-stage
// watchdog and a saturating run-length counter. All outputs registered; no bubble between stages.
module slda_stage_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 0
) (
  input logic                   clock,
  input logic                   reset,
  slda_stage_sequencer_if.slave bus
);
  localparam int SEL_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t                state_q;
  logic [NUM_STAGES-1:0] mask_q;
  logic [NUM_STAGES-1:0] stage_start_q;
  logic [SEL_W-1:0]      sel_q;
  logic [CNT_W-1:0]      run_cnt_q;
  logic [CNT_W-1:0]      stage_cnt_q;
  logic [CNT_W-1:0]      run_cycles_q;
  logic                  ap_ready_q;
  logic                  ap_done_q;
  logic                  err_timeout_q;

  logic                  first_vld;
  logic [SEL_W-1:0]      first_idx;
  logic                  next_vld;
  logic [SEL_W-1:0]      next_idx;
  logic [CNT_W-1:0]      run_cnt_d;
  logic [CNT_W-1:0]      stage_cnt_d;
  logic                  stage_fin;
  logic                  wd_hit;

  always_comb begin
    first_vld = 1'b0;
    first_idx = '0;
    next_vld  = 1'b0;
    next_idx  = '0;
    // Descending scan so the lowest qualifying index is the one left standing.
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!bus.skip_mask[i]) begin
        first_vld = 1'b1;
        first_idx = SEL_W'(i);
      end
      if (!mask_q[i] && (i > int'(sel_q))) begin
        next_vld = 1'b1;
        next_idx = SEL_W'(i);
      end
    end
    run_cnt_d   = (&run_cnt_q)   ? run_cnt_q   : run_cnt_q + CNT_W'(1);
    stage_cnt_d = (&stage_cnt_q) ? stage_cnt_q : stage_cnt_q + CNT_W'(1);
    stage_fin   = ((state_q == START) && bus.stage_ready[sel_q] && bus.stage_done[sel_q]) ||
                  ((state_q == RUN) && bus.stage_done[sel_q]);
    wd_hit      = (TIMEOUT != 0) && (stage_cnt_q == CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      mask_q        <= '0;
      stage_start_q <= '0;
      sel_q         <= '0;
      run_cnt_q     <= '0;
      stage_cnt_q   <= '0;
      run_cycles_q  <= '0;
      ap_ready_q    <= 1'b0;
      ap_done_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      ap_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.ap_start) begin
            mask_q        <= bus.skip_mask;
            run_cnt_q     <= '0;
            stage_cnt_q   <= '0;
            ap_ready_q    <= 1'b1;
            err_timeout_q <= 1'b0;
            if (first_vld) begin
              state_q                  <= START;
              sel_q                    <= first_idx;
              stage_start_q            <= '0;
              stage_start_q[first_idx] <= 1'b1;
            end else begin
              state_q      <= DONE;
              ap_done_q    <= 1'b1;
              run_cycles_q <= '0;
            end
          end
        end
        START, RUN: begin
          run_cnt_q   <= run_cnt_d;
          stage_cnt_q <= stage_cnt_d;
          if (stage_fin && next_vld) begin
            state_q                 <= START;
            sel_q                   <= next_idx;
            stage_start_q           <= '0;
            stage_start_q[next_idx] <= 1'b1;
            stage_cnt_q             <= '0;
          end else if (stage_fin || wd_hit) begin
            // The current cycle is still a START/RUN cycle, so it is included in the copy.
            state_q       <= DONE;
            ap_done_q     <= 1'b1;
            stage_start_q <= '0;
            sel_q         <= '0;
            run_cycles_q  <= run_cnt_d;
            err_timeout_q <= !stage_fin;
          end else if ((state_q == START) && bus.stage_ready[sel_q]) begin
            state_q       <= RUN;
            stage_start_q <= '0;
          end
        end
        DONE: begin
          if (bus.ap_continue) begin
            state_q   <= IDLE;
            ap_done_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ap_ready    = ap_ready_q;
  assign bus.ap_done     = ap_done_q;
  assign bus.ap_idle     = (state_q == IDLE);
  assign bus.stage_start = stage_start_q;
  assign bus.stage_sel   = sel_q;
  assign bus.run_cycles  = run_cycles_q;
  assign bus.err_timeout = err_timeout_q;
endmodule

// File: tb/tb_slda_stage_sequencer.sv
// Self-checking bench for slda_stage_sequencer: directed scenarios plus randomized runs,
// checked against a timeline model built from per-stage kernel latencies.
module tb_slda_stage_sequencer;
  localparam int NS = 3;
  localparam int CW = 32;
  localparam int TO = 16;

  logic clock;
  logic reset;

  slda_stage_sequencer_if #(.NUM_STAGES(NS), .CNT_W(CW)) bus ();

  slda_stage_sequencer #(.NUM_STAGES(NS), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Kernel behaviour: ready rdy_lat cycles and done done_lat cycles after its start rises.
  int rdy_lat[NS];
  int done_lat[NS];
  int hang_stage;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_nominal();
    for (int i = 0; i < NS; i++) begin
      rdy_lat[i]  = 1;
      done_lat[i] = 10;
    end
    hang_stage = -1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_idle"},  bus.ap_idle, 1);
    chk({tag, "_ready"}, bus.ap_ready, 0);
    chk({tag, "_done"},  bus.ap_done, 0);
    chk({tag, "_start"}, bus.stage_start, 0);
    chk({tag, "_sel"},   bus.stage_sel, 0);
    chk({tag, "_rcyc"},  bus.run_cycles, 0);
    chk({tag, "_err"},   bus.err_timeout, 0);
  endtask

  // Call at a negedge. cont_delay < 0 holds ap_continue high throughout.
  // spur: 0 none, 1 random, 2 every non-active stage every cycle.
  task automatic do_run(input logic [NS-1:0] mask, input int cont_delay, input bit hold_start,
                        input int spur, input int abort_at);
    int  s_seen[NS];
    int  exp_s[NS];
    int  t;
    int  done_c;
    int  ready_cnt;
    int  active;
    int  j;
    bit  exp_to;
    bit  fin;
    logic [NS-1:0] rdy;
    logic [NS-1:0] dn;

    t = 0;
    exp_to = 1'b0;
    for (int i = 0; i < NS; i++) begin
      exp_s[i]  = -1;
      s_seen[i] = -1;
      if (!mask[i] && !exp_to) begin
        exp_s[i] = t;
        if (i == hang_stage) begin
          t += TO;
          exp_to = 1'b1;
        end else begin
          t += done_lat[i] + 1;
        end
      end
    end

    done_c    = -1;
    ready_cnt = 0;
    fin       = 1'b0;
    bus.ap_start    = 1'b1;
    bus.skip_mask   = mask;
    bus.ap_continue = (cont_delay < 0);
    @(posedge clock);
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge clock);
      if (bus.ap_ready) ready_cnt++;
      chk("ap_ready_pulse", bus.ap_ready, (c == 0));
      if (c == 0) chk("err_cleared_on_start", bus.err_timeout, 0);
      chk("start_onehot", ($countones(bus.stage_start) <= 1), 1);
      for (int i = 0; i < NS; i++) begin
        if (bus.stage_start[i] && s_seen[i] < 0) begin
          s_seen[i] = c;
          chk("stage_sel", bus.stage_sel, i);
        end
      end
      if (bus.ap_done && done_c < 0) done_c = c;
      if (done_c >= 0 && !bus.ap_done) begin
        fin = 1'b1;
        chk("idle_on_done_fall", bus.ap_idle, 1);
        chk("done_len", c - done_c, ((cont_delay < 0) ? 0 : cont_delay) + 1);
      end else begin
        if (done_c < 0) chk("not_idle", bus.ap_idle, 0);
        rdy = '0;
        dn  = '0;
        active = -1;
        for (int i = 0; i < NS; i++) begin
          if (s_seen[i] >= 0) begin
            if (c == s_seen[i] + rdy_lat[i]) rdy[i] = 1'b1;
            if (i != hang_stage && c == s_seen[i] + done_lat[i]) dn[i] = 1'b1;
            if (done_c < 0 && (i == hang_stage || c <= s_seen[i] + done_lat[i])) active = i;
          end
        end
        if (spur == 2) begin
          for (int k = 0; k < NS; k++)
            if (k != active) begin
              dn[k]  = 1'b1;
              rdy[k] = 1'b1;
            end
        end else if (spur == 1 && $urandom_range(0, 2) == 0) begin
          j = $urandom_range(0, NS - 1);
          if (j != active) dn[j] = 1'b1;
        end
        bus.stage_ready = rdy;
        bus.stage_done  = dn;
        bus.ap_continue = (cont_delay < 0) || (done_c >= 0 && c >= done_c + cont_delay);
        if (!hold_start) bus.ap_start = 1'b0;
        if (c == abort_at) return;
      end
    end
    bus.stage_ready = '0;
    bus.stage_done  = '0;
    if (cont_delay >= 0) bus.ap_continue = 1'b0;
    if (!hold_start) bus.ap_start = 1'b0;
    chk("run_finished", fin, 1);
    chk("done_cycle", done_c, t);
    chk("run_cycles", bus.run_cycles, t);
    chk("err_timeout", bus.err_timeout, exp_to);
    chk("ready_count", ready_cnt, 1);
    for (int i = 0; i < NS; i++) chk($sformatf("start_cycle_%0d", i), s_seen[i], exp_s[i]);
  endtask

  initial begin
    reset           = 1'b1;
    bus.ap_start    = 1'b0;
    bus.ap_continue = 1'b0;
    bus.skip_mask   = '0;
    bus.stage_ready = '0;
    bus.stage_done  = '0;
    set_nominal();
    #2;
    chk_reset_vals("reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk_reset_vals("after_reset");

    // Nominal: 3 x 11 cycles, continue held high.
    do_run(3'b000, -1, 1'b0, 0, -1);
    chk("nominal_rcyc", bus.run_cycles, 33);

    // Skip stage 1.
    do_run(3'b010, 0, 1'b0, 0, -1);
    chk("skip1_rcyc", bus.run_cycles, 22);

    // All skipped: ap_done with ap_ready, run_cycles 0.
    do_run(3'b111, 0, 1'b0, 0, -1);

    // Ready and done coincident on stage 0.
    rdy_lat[0] = 3;
    done_lat[0] = 3;
    do_run(3'b000, 0, 1'b0, 0, -1);

    // Spurious ready/done on every non-selected stage.
    set_nominal();
    rdy_lat[0] = 1;
    done_lat[0] = 8;
    do_run(3'b000, 0, 1'b0, 2, -1);

    // Watchdog: stage 1 never finishes.
    set_nominal();
    hang_stage = 1;
    do_run(3'b000, 0, 1'b0, 0, -1);
    chk("wd_rcyc", bus.run_cycles, 27);
    chk("wd_err", bus.err_timeout, 1);
    set_nominal();

    // ap_continue held low for 5 ap_done cycles with ap_start high; re-accept right after idle.
    do_run(3'b000, 5, 1'b1, 0, -1);
    do_run(3'b000, 0, 1'b0, 0, -1);

    // Reset asynchronously while stage 1 is in RUN.
    do_run(3'b000, 0, 1'b0, 0, 14);
    chk("pre_reset_busy", bus.ap_idle, 0);
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    bus.stage_ready = '0;
    bus.stage_done  = '0;
    bus.ap_start    = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    do_run(3'b000, -1, 1'b0, 0, -1);
    chk("post_reset_rcyc", bus.run_cycles, 33);

    // Randomized runs.
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < NS; i++) begin
        rdy_lat[i]  = $urandom_range(0, 3);
        done_lat[i] = rdy_lat[i] + $urandom_range(0, 8);
      end
      hang_stage = ($urandom_range(0, 4) == 0) ? $urandom_range(0, NS - 1) : -1;
      do_run(NS'($urandom_range(0, 7)), $urandom_range(0, 3), 1'b0, 1, -1);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
